// File: rtl/giris_debounce.sv
// giris_debounce: 2-flop synchroniser plus per-channel stable-count debounce of four raw switch levels onto a/b/c/d.
// Latency: a held level appears on a..d, with a one-cycle degisti strobe, at edge STABLE_CYCLES+2 after it is first sampled.
// Backpressure: none; a free-running level conditioner where each channel can change at most once per STABLE_CYCLES cycles.
module giris_debounce #(
    parameter int STABLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       degisti
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    // Per-channel state is implied by the synchronised level versus the output.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    q;
    logic [3:0]    commit;
    logic [0:0]    st  [4];
    logic [CW-1:0] cnt [4];

    // Two-flop synchroniser on all raw inputs; bit ordering is preserved.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_in;
            s2 <= s1;
        end
    end

    // Classify each channel and flag the edge where its window has fully elapsed.
    always_comb begin
        commit = '0;
        for (int i = 0; i < 4; i++) begin
            st[i]     = (s2[i] != q[i]) ? ST_COUNT : ST_IDLE;
            commit[i] = (st[i] == ST_COUNT) && (cnt[i] == CNT_LAST);
        end
    end

    // Stable counters and output flops; any return to the output level restarts the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (st[i] == ST_IDLE) begin
                    cnt[i] <= '0;
                end else if (commit[i]) begin
                    q[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Change strobe: one pulse per commit edge, aligned with the new output values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            degisti <= 1'b0;
        end else begin
            degisti <= |commit;
        end
    end

    assign a = q[3];
    assign b = q[2];
    assign c = q[1];
    assign d = q[0];

endmodule

// File: tb/tb_giris_debounce.sv
// tb_giris_debounce: scoreboard bench for the four-channel debouncer at STABLE_CYCLES = 8.
// Latency: expected {a,b,c,d,degisti} per edge is queued from the timeline, popped and compared 1 time unit after each edge.
// Backpressure: none; stimulus is a fixed per-edge sw_in pattern.
`timescale 1ns/1ps
module tb_giris_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_in;
    logic       a, b, c, d, degisti;

    typedef struct packed {
        logic [3:0] q;
        logic       dg;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    giris_debounce #(.STABLE_CYCLES(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_in   (sw_in),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .degisti (degisti)
    );

    always #5 clk = ~clk;

    // Drive one input level, let one rising edge pass, settle before sampling.
    task automatic step(input logic [3:0] sw);
        sw_in = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] qv, input logic dg);
        exp_t e;
        e.q  = qv;
        e.dg = dg;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(4'b0000);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        exp_t       want;
        rst_n = 1'b0;
        for (int e = 1; e <= 3; e++) push_exp(4'b0000, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            step(4'b1111);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL reset_hold edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL reset_hold edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 11; e++) push_exp((e >= 10) ? 4'b1111 : 4'b0000, e == 10);
        for (int e = 1; e <= 11; e++) begin
            step(4'b1111);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL reset_release edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL reset_release edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
    endtask

    task automatic test_single_change();
        logic [4:0] got;
        exp_t       want;
        do_reset();
        for (int e = 1; e <= 12; e++) push_exp((e >= 10) ? 4'b0100 : 4'b0000, e == 10);
        for (int e = 1; e <= 12; e++) begin
            step(4'b0100);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL single_change edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL single_change edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [4:0] got;
        exp_t       want;
        do_reset();
        // 7-cycle pulse: one edge short of the window, must vanish.
        for (int e = 1; e <= 20; e++) push_exp(4'b0000, 1'b0);
        for (int e = 1; e <= 20; e++) begin
            step((e <= 7) ? 4'b0001 : 4'b0000);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL glitch7 edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL glitch7 edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
        // 8-cycle pulse: accepted at edge 10, and its falling edge (sampled at 9) commits at 18.
        for (int e = 1; e <= 20; e++) push_exp((e >= 10 && e < 18) ? 4'b0001 : 4'b0000, (e == 10) || (e == 18));
        for (int e = 1; e <= 20; e++) begin
            step((e <= 8) ? 4'b0001 : 4'b0000);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL pulse8 edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL pulse8 edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] got;
        exp_t       want;
        do_reset();
        // Final rising sample at edge 7, so c commits at edge 16.
        for (int e = 1; e <= 18; e++) push_exp((e >= 16) ? 4'b0010 : 4'b0000, e == 16);
        for (int e = 1; e <= 18; e++) begin
            step((e == 6) ? 4'b0000 : 4'b0010);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL bounce edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL bounce edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [4:0] got;
        exp_t       want;
        do_reset();
        for (int e = 1; e <= 12; e++) push_exp((e >= 10) ? 4'b1011 : 4'b0000, e == 10);
        for (int e = 1; e <= 12; e++) begin
            step(4'b1011);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL simultaneous edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL simultaneous edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got;
        exp_t       want;
        logic [3:0] qv;
        do_reset();
        // a sampled at edge 1, b at edge 2: commits on edges 10 and 11, two adjacent strobes.
        for (int e = 1; e <= 13; e++) begin
            qv = 4'b0000;
            if (e >= 10) qv[3] = 1'b1;
            if (e >= 11) qv[2] = 1'b1;
            push_exp(qv, (e == 10) || (e == 11));
        end
        for (int e = 1; e <= 13; e++) begin
            step((e == 1) ? 4'b1000 : 4'b1100);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL back_to_back edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL back_to_back edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [4:0] got;
        exp_t       want;
        do_reset();
        // Six counting edges then a one-cycle reset: nothing may leak out.
        for (int e = 1; e <= 7; e++) push_exp(4'b0000, 1'b0);
        for (int e = 1; e <= 7; e++) begin
            if (e == 7) rst_n = 1'b0;
            step(4'b1000);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL reset_mid_pre edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL reset_mid_pre edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) push_exp((e >= 10) ? 4'b1000 : 4'b0000, e == 10);
        for (int e = 1; e <= 12; e++) begin
            step(4'b1000);
            got = {a, b, c, d, degisti};
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL reset_mid_post edge %0d scoreboard empty got=%b", e, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    failures++; $display("FAIL reset_mid_post edge %0d got=%b want=%b", e, got, want);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sw_in = 4'b0000;
        test_reset();
        test_single_change();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_count();
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain leftover=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t limit=100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/giris_debounce.md
# giris_debounce

Four-channel input conditioner that sits directly upstream of the `sop_genisletilmis` sum-of-products evaluator. It takes raw asynchronous switch/button levels, synchronises and debounces each channel independently, and drives the stable `a`, `b`, `c`, `d` levels the evaluator consumes. It also emits a single-cycle `degisti` strobe whenever any debounced level changes, so downstream logic can sample the evaluator output `x` only on real input changes.

## Interface
- `STABLE_CYCLES`, default 8: consecutive clock cycles a synchronised level must differ from the current output before the output is updated.
  - Legal range is 2..65535.
  - Counter width is `$clog2(STABLE_CYCLES)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `sw_in`  in  4  raw asynchronous inputs; bit 3 maps to `a`, bit 2 to `b`, bit 1 to `c`, bit 0 to `d`.
- `a`  out  1  debounced `sw_in[3]`; registered.
- `b`  out  1  debounced `sw_in[2]`; registered.
- `c`  out  1  debounced `sw_in[1]`; registered.
- `d`  out  1  debounced `sw_in[0]`; registered.
- `degisti`  out  1  one-cycle strobe, high in the cycle where any of `a..d` first shows a new value.

## Operation
- **Per-channel datapath:** 2-flop synchroniser `s1 -> s2`, one stable counter `cnt`, one output flop `q` (`q` is `a`/`b`/`c`/`d`).
- **Per-channel states:**
  - IDLE: `s2 == q`.
  - COUNT: `s2 != q`, `cnt` running.
- **Rules at each rising edge with `rst_n = 1`:**
  - `s2 == q`: `cnt <= 0` (covers both IDLE and abort from COUNT).
  - `s2 != q` and `cnt == STABLE_CYCLES-1`: `q <= s2`, `cnt <= 0` (commit).
  - `s2 != q` otherwise: `cnt <= cnt + 1`.
- **Glitches:** any pulse at `s2` shorter than `STABLE_CYCLES` cycles produces no output change and leaves `cnt` at 0 afterwards.
- **Channel independence:** channels share no counter. Simultaneous commits on several channels occur on the same edge.
- **`degisti`:**
  - Registered: `degisti <= OR(commit of any channel)`.
  - It is high exactly in the cycle the new `q` values are visible.
  - Multiple channels committing on the same edge produce one pulse.
  - Commits on consecutive edges produce consecutive high cycles.
- **Reset (synchronous, `rst_n = 0` at an edge):** `s1`, `s2`, `cnt`, `a`, `b`, `c`, `d` and `degisti` all go to 0.
  - Reset mid-count discards the count.
  - After release, an input held at 1 needs the full latency below to appear.
- **No arithmetic overflow:** `cnt` never exceeds `STABLE_CYCLES-1`.

## Timing
- **Output reset values:** `a = b = c = d = 0`, `degisti = 0`.
- **Latency:** number the first edge that samples a new, held `sw_in` level as edge 1.
  - `s2` shows the new level after edge 2.
  - `q` and `degisti` update at edge `STABLE_CYCLES+2` (edge 10 for the default).
- **Minimum accepted pulse:** a level held at `s2` for at least `STABLE_CYCLES` consecutive edges is accepted. A level held one cycle less is rejected.
- **Bounce inside the window:**
  - A return to the old level restarts the count from 0.
  - The full window is then required again from the next difference.
- **`degisti` width:** always exactly 1 cycle per commit edge. It is never asserted during or immediately after reset.
- **Throughput:** each channel can toggle at most once per `STABLE_CYCLES` cycles.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n = 0` 3 cycles with `sw_in = 4'b1111`, then release.
  - Required: `a..d = 0` and `degisti = 0` throughout reset; `a..d = 1` and `degisti = 1` at edge 10 after release; `degisti = 0` at edge 11.
- **Single clean change:**
  - Stimulus: `sw_in` goes `0000 -> 0100`.
  - Required: `b` rises exactly at edge 10 (numbered from the first sampling edge); `degisti` pulses 1 cycle; `a`, `c`, `d` stay 0.
- **Glitch rejection:**
  - Stimulus: 7-cycle high pulse on `sw_in[0]`.
  - Required: `d` stays 0 and `degisti` stays 0.
  - Stimulus: 8-cycle pulse on `sw_in[0]`.
  - Required: `d` rises.
- **Bounce restart:**
  - Stimulus: `sw_in[1]` high 5 cycles, low 1 cycle, then high steadily.
  - Required: `c` rises 10 edges after the final rising sample (no credit for the first 5 cycles).
- **Simultaneous change:**
  - Stimulus: `sw_in` goes `0000 -> 1011` on one edge.
  - Required: `a`, `c`, `d` update on the same edge; exactly one `degisti` pulse.
- **Reset mid-count:**
  - Stimulus: `sw_in[3]` high for 6 cycles, assert `rst_n = 0` for 1 cycle, release with `sw_in[3]` still high.
  - Required: `a = 0` until edge 10 after release, then 1.
